// File: rtl/store_port_arbiter.sv
// store_port_arbiter
//   Shares the single data-cache store port between NrPorts store requesters.
//   A round-robin arbiter captures one request per cycle into a registered
//   request stage that is held until the cache grants it. Port IDs of
//   cache-granted writes are queued in a small FIFO so that in-order write
//   acks can be routed back to their requester. The number of cache-granted,
//   un-acked writes plus the held request never exceeds MaxOutstanding.
//
// Ports
//   clk_i, rst_i        clock (rising edge), synchronous active-high reset
//   flush_i             suppresses capture (and gnt_o) for the cycle
//   req_i/addr_i/data_i/be_i/size_i   per-port request, packed port-major
//   gnt_o               one-hot, request of that port captured this cycle
//   ack_o               one-hot, write of that port acknowledged this cycle
//   dreq_*_o            registered request towards the cache
//   dreq_gnt_i          cache accepted the held request
//   dresp_ack_i         cache completed the oldest outstanding write
//   idle_o              no held request and nothing in flight
//   err_o               sticky: ack received while nothing was in flight
module store_port_arbiter #(
    parameter int NrPorts        = 3,
    parameter int AddrWidth      = 56,
    parameter int DataWidth      = 64,
    parameter int MaxOutstanding = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic [NrPorts-1:0]             req_i,
    input  logic [NrPorts*AddrWidth-1:0]   addr_i,
    input  logic [NrPorts*DataWidth-1:0]   data_i,
    input  logic [NrPorts*DataWidth/8-1:0] be_i,
    input  logic [NrPorts*2-1:0]           size_i,
    output logic [NrPorts-1:0]             gnt_o,
    output logic [NrPorts-1:0]             ack_o,
    output logic                           dreq_valid_o,
    output logic [AddrWidth-1:0]           dreq_addr_o,
    output logic [DataWidth-1:0]           dreq_data_o,
    output logic [DataWidth/8-1:0]         dreq_be_o,
    output logic [1:0]                     dreq_size_o,
    input  logic                           dreq_gnt_i,
    input  logic                           dresp_ack_i,
    output logic                           idle_o,
    output logic                           err_o
);

    localparam int BeWidth = DataWidth / 8;
    localparam int PortW   = (NrPorts > 1) ? $clog2(NrPorts) : 1;
    localparam int PtrW    = $clog2(MaxOutstanding);
    localparam int CntW    = PtrW + 1;

    // Held request stage
    logic                 dreq_valid_r;
    logic [AddrWidth-1:0] dreq_addr_r;
    logic [DataWidth-1:0] dreq_data_r;
    logic [BeWidth-1:0]   dreq_be_r;
    logic [1:0]           dreq_size_r;
    logic [PortW-1:0]     dreq_port_r;

    // Arbitration and in-flight tracking state
    logic [PortW-1:0]     rr_ptr_r;
    logic [PortW-1:0]     fifo_r [MaxOutstanding];
    logic [PtrW-1:0]      wr_ptr_r;
    logic [PtrW-1:0]      rd_ptr_r;
    logic [CntW-1:0]      inflight_r;
    logic                 err_r;

    logic                 found_s;
    logic [PortW-1:0]     sel_s;
    logic [PortW:0]       probe_s;
    logic [PortW-1:0]     idx_s;
    logic [PortW-1:0]     rr_next_s;
    logic [CntW:0]        occupancy_s;
    logic                 free_s;
    logic                 cap_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 stray_ack_s;

    // Round-robin search: first requesting port at or after rr_ptr_r, wrapping.
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        probe_s = '0;
        idx_s   = '0;
        for (int i = 0; i < NrPorts; i++) begin
            probe_s = {1'b0, rr_ptr_r} + (PortW+1)'(i);
            idx_s   = (probe_s >= (PortW+1)'(NrPorts)) ?
                      PortW'(probe_s - (PortW+1)'(NrPorts)) : PortW'(probe_s);
            sel_s   = (req_i[idx_s] && !found_s) ? idx_s : sel_s;
            found_s = found_s | req_i[idx_s];
        end
    end

    // Capture decision; the held request counts against the outstanding budget
    // so that a capture can never overflow the ID FIFO once it is granted.
    always_comb begin
        free_s      = !dreq_valid_r || dreq_gnt_i;
        occupancy_s = {1'b0, inflight_r} + {{CntW{1'b0}}, dreq_valid_r};
        cap_s       = free_s && !flush_i && found_s &&
                      (occupancy_s < (CntW+1)'(MaxOutstanding));
        rr_next_s   = (sel_s == PortW'(NrPorts - 1)) ? '0 : sel_s + PortW'(1);
        push_s      = dreq_valid_r && dreq_gnt_i;
        pop_s       = dresp_ack_i && (inflight_r != '0);
        stray_ack_s = dresp_ack_i && (inflight_r == '0);
    end

    // One-hot grant to the selected requester and ack to the oldest in-flight port.
    always_comb begin
        gnt_o = '0;
        ack_o = '0;
        if (cap_s) begin
            gnt_o[sel_s] = 1'b1;
        end else begin
            gnt_o = '0;
        end
        if (pop_s) begin
            ack_o[fifo_r[rd_ptr_r]] = 1'b1;
        end else begin
            ack_o = '0;
        end
    end

    // Held request register: loads on capture, drops once granted without a refill.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dreq_valid_r <= 1'b0;
            dreq_addr_r  <= '0;
            dreq_data_r  <= '0;
            dreq_be_r    <= '0;
            dreq_size_r  <= 2'b00;
            dreq_port_r  <= '0;
            rr_ptr_r     <= '0;
        end else if (cap_s) begin
            dreq_valid_r <= 1'b1;
            dreq_addr_r  <= addr_i[sel_s*AddrWidth +: AddrWidth];
            dreq_data_r  <= data_i[sel_s*DataWidth +: DataWidth];
            dreq_be_r    <= be_i[sel_s*BeWidth +: BeWidth];
            dreq_size_r  <= size_i[sel_s*2 +: 2];
            dreq_port_r  <= sel_s;
            rr_ptr_r     <= rr_next_s;
        end else if (dreq_gnt_i) begin
            dreq_valid_r <= 1'b0;
        end
    end

    // Port-ID FIFO and in-flight counter; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < MaxOutstanding; i++) begin
                fifo_r[i] <= '0;
            end
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            inflight_r <= '0;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= dreq_port_r;
                wr_ptr_r         <= wr_ptr_r + PtrW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PtrW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   inflight_r <= inflight_r + CntW'(1);
                2'b01:   inflight_r <= inflight_r - CntW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Sticky protocol error: an ack arrived with nothing in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else if (stray_ack_s) begin
            err_r <= 1'b1;
        end
    end

    assign dreq_valid_o = dreq_valid_r;
    assign dreq_addr_o  = dreq_addr_r;
    assign dreq_data_o  = dreq_data_r;
    assign dreq_be_o    = dreq_be_r;
    assign dreq_size_o  = dreq_size_r;
    assign idle_o       = !dreq_valid_r && (inflight_r == '0);
    assign err_o        = err_r;

endmodule
